match_scoreboard: RTL
=====================

# match_scoreboard

Parametrised round/score tracker for the two-player game datapath. It sits after the match-result logic and accepts one result per handshake, counting rounds, player-1 wins, player-2 wins and draws, plus the current player-1 win streak. A two-state FSM detects the end of a match: first to TARGET_WINS wins, or the round limit is reached. The block then holds its final score until a new match is requested. It supersedes the fixed 4-bit round/win/lose counter for all new game logic.

## Interface

- CNT_W, 4: width of every counter output.
- TARGET_WINS, 3: wins needed to take the match; legal range 1..2^CNT_W-1.
- MAX_ROUNDS, 5: round limit; 0 means no limit; otherwise 1..2^CNT_W-1.

- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-high reset (the name is historical; 1 = reset).
- result_valid  in  1  result present this cycle.
- result  in  2  00 no-op, 01 draw, 10 player-1 win, 11 player-2 win.
- result_ready  out  1  block accepts results; equals state==PLAY.
- new_match  in  1  one-cycle pulse; clears the score and returns the FSM to PLAY.
- round  out  CNT_W  counted rounds (01/10/11 results).
- win  out  CNT_W  player-1 wins.
- lose  out  CNT_W  player-2 wins.
- draw  out  CNT_W  draws.
- streak  out  CNT_W  consecutive player-1 wins ending at the latest round.
- match_over  out  1  1 while the FSM is in OVER.
- match_winner  out  2  00 undecided, 10 player 1, 11 player 2, 01 tie; valid when match_over=1.

## Operation

- An accept happens when result_valid & result_ready & ~new_match & ~resetn.
- An accepted 00 changes nothing and is not a round.
- Accepted 01: round+1, draw+1, streak←0.
- Accepted 10: round+1, win+1, streak+1.
- Accepted 11: round+1, lose+1, streak←0.
- All counters saturate at 2^CNT_W-1 and hold; no wrap. Saturation is only reachable with MAX_ROUNDS=0.
- FSM states:
  - PLAY (reset state): accepts results.
  - OVER: results ignored, result_ready=0, counters frozen.
- PLAY→OVER on the same edge that registers the deciding result. End conditions are evaluated on the post-increment values, in priority order:
  - win_next==TARGET_WINS → match_winner 10.
  - lose_next==TARGET_WINS → match_winner 11.
  - MAX_ROUNDS≠0 and round_next==MAX_ROUNDS → winner by comparison of win_next and lose_next: 10, 11, or 01 when equal.
- OVER→PLAY on new_match. new_match in PLAY also clears the score mid-match.
- new_match clears round, win, lose, draw, streak, match_over and match_winner to 0, from either state.
- new_match has priority over a coincident result_valid; that result is dropped, not counted.
- resetn has priority over everything else.

## Timing

- Reset value of every output: round=win=lose=draw=streak=0, match_over=0, match_winner=00, result_ready=1.
- All outputs except result_ready are registered. The response to an accept is visible one cycle after the accepting edge.
- result_ready is combinational from state only. It never depends on result_valid.
- Back-to-back accepts are allowed, one per cycle, with no bubbles.
- match_over and match_winner rise in the same cycle as the counter update that decided the match.
- The first accept after new_match can happen in the cycle following the new_match pulse.
- Asserting resetn mid-match clears everything at the next edge. Any result presented in that cycle is lost.

## Test plan

- Reset, then results 10,10,10 on consecutive cycles (defaults) → win=3, round=3, streak=3; match_over=1 and match_winner=10 in the cycle after the 3rd accept; result_ready=0.
- Sequence 10,11,01,11,01 → round=5, win=1, lose=2, draw=2, streak=0; match ends on round limit with match_winner=11.
- Sequence 10,11,01,01,01 → round=5, win=1, lose=1, draw=3; match_winner=01 (tie).
- In OVER, drive result_valid=1 with 10 for 4 cycles → all counters unchanged. Then new_match together with result_valid=1 and 10 → all counters 0, FSM in PLAY, result not counted.
- Sequence 00,00,10 → round=1, win=1 (no-ops ignored). Then assert resetn while result_valid=1 with 11 → all outputs 0 at the next edge, lose stays 0.
- CNT_W=2, MAX_ROUNDS=0, TARGET_WINS=3: six 01 draws → draw=3 and round=3, both saturated; match_over stays 0.

Source files
------------

// File: rtl/match_scoreboard_if.sv
// Result handshake and score outputs of the match scoreboard.
// The master side feeds results; the slave side is the scoreboard itself.
interface match_scoreboard_if #(
  parameter int unsigned CNT_W = 4
);
  logic             result_valid;
  logic [1:0]       result;
  logic             result_ready;
  logic             new_match;
  logic [CNT_W-1:0] round;
  logic [CNT_W-1:0] win;
  logic [CNT_W-1:0] lose;
  logic [CNT_W-1:0] draw;
  logic [CNT_W-1:0] streak;
  logic             match_over;
  logic [1:0]       match_winner;

  modport master (
    output result_valid, result, new_match,
    input  result_ready, round, win, lose, draw, streak, match_over, match_winner
  );

  modport slave (
    input  result_valid, result, new_match,
    output result_ready, round, win, lose, draw, streak, match_over, match_winner
  );
endinterface

// File: rtl/match_scoreboard.sv
// Round/score tracker: counts rounds, wins, losses, draws and the player-1 streak,
// and latches the match result until a new match is requested.
module match_scoreboard #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TARGET_WINS = 3,
  parameter int unsigned MAX_ROUNDS  = 5
) (
  input  logic               clk,
  input  logic               resetn,
  match_scoreboard_if.slave  sb
);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam logic [1:0] RES_NOP  = 2'b00;
  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_P1   = 2'b10;
  localparam logic [1:0] RES_P2   = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TIE  = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b11;

  localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET_WINS);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_ROUNDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] lose_q, lose_d;
  logic [CNT_W-1:0] draw_q, draw_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign accept = sb.result_valid && (state_q == PLAY) && !sb.new_match;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    win_d    = win_q;
    lose_d   = lose_q;
    draw_d   = draw_q;
    streak_d = streak_q;
    over_d   = over_q;
    winner_d = winner_q;

    if (sb.new_match) begin
      state_d  = PLAY;
      round_d  = '0;
      win_d    = '0;
      lose_d   = '0;
      draw_d   = '0;
      streak_d = '0;
      over_d   = 1'b0;
      winner_d = WIN_NONE;
    end else if (accept && (sb.result != RES_NOP)) begin
      round_d = sat_inc(round_q);
      case (sb.result)
        RES_DRAW: begin
          draw_d   = sat_inc(draw_q);
          streak_d = '0;
        end
        RES_P1: begin
          win_d    = sat_inc(win_q);
          streak_d = sat_inc(streak_q);
        end
        RES_P2: begin
          lose_d   = sat_inc(lose_q);
          streak_d = '0;
        end
        default: ;
      endcase

      // End conditions use post-increment counts so the deciding round and the
      // result flags land on the same edge.
      if (win_d == TARGET_C) begin
        state_d  = OVER;
        over_d   = 1'b1;
        winner_d = WIN_P1;
      end else if (lose_d == TARGET_C) begin
        state_d  = OVER;
        over_d   = 1'b1;
        winner_d = WIN_P2;
      end else if ((MAX_ROUNDS != 0) && (round_d == MAX_C)) begin
        state_d  = OVER;
        over_d   = 1'b1;
        if (win_d > lose_d)      winner_d = WIN_P1;
        else if (lose_d > win_d) winner_d = WIN_P2;
        else                     winner_d = WIN_TIE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= PLAY;
      round_q  <= '0;
      win_q    <= '0;
      lose_q   <= '0;
      draw_q   <= '0;
      streak_q <= '0;
      over_q   <= 1'b0;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      draw_q   <= draw_d;
      streak_q <= streak_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign sb.result_ready = (state_q == PLAY);
  assign sb.round        = round_q;
  assign sb.win          = win_q;
  assign sb.lose         = lose_q;
  assign sb.draw         = draw_q;
  assign sb.streak       = streak_q;
  assign sb.match_over   = over_q;
  assign sb.match_winner = winner_q;

endmodule
